// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared state encodings and master indices for the bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant/select bundle between bus masters and the arbiter
interface bus_arbiter_if;
    logic m0_req;
    logic m1_req;
    logic m0_grant;
    logic m1_grant;
    logic m_sel;
    logic bus_busy;

    modport slave (
        input  m0_req,
        input  m1_req,
        output m0_grant,
        output m1_grant,
        output m_sel,
        output bus_busy
    );

    modport master (
        output m0_req,
        output m1_req,
        input  m0_grant,
        input  m1_grant,
        input  m_sel,
        input  bus_busy
    );
endinterface

// File: rtl/arb_hold_counter.sv
// rtl/arb_hold_counter.sv - clear/enable/saturating tenure counter with terminal flag at MAX_HOLD-1
module arb_hold_counter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);
    // With preemption disabled the counter simply saturates at all-ones and never flags.
    localparam int                 SAT   = (MAX_HOLD == 0) ? ((2 ** CNT_W) - 1) : (MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]   SAT_V = CNT_W'(SAT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != SAT_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_term = (MAX_HOLD != 0) && (r_cnt == SAT_V);

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master bus arbiter with bounded tenure; ARB_ROUND_ROBIN_EN selects alternating tie-break
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    bus_arbiter_if.slave   bus
);
    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last;
    logic       r_sel;
    logic       w_clr;
    logic       w_en;
    logic       w_term;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= M1;
            r_sel   <= M0;
        end else begin
            r_state <= w_next;
            if (w_next == GNT0 && r_state != GNT0) begin
                r_last <= M0;
                r_sel  <= M0;
            end else if (w_next == GNT1 && r_state != GNT1) begin
                r_last <= M1;
                r_sel  <= M1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.m0_req && bus.m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    w_next = (r_last == M0) ? GNT1 : GNT0;
`else
                    w_next = GNT0;
`endif
                end else if (bus.m0_req) begin
                    w_next = GNT0;
                end else if (bus.m1_req) begin
                    w_next = GNT1;
                end
            end
            GNT0: begin
                w_en = bus.m1_req;
                if (!bus.m0_req) begin
                    w_next = bus.m1_req ? GNT1 : IDLE;
                end else if (bus.m1_req && w_term) begin
                    w_next = GNT1;
                end
            end
            GNT1: begin
                w_en = bus.m0_req;
                if (!bus.m1_req) begin
                    w_next = bus.m0_req ? GNT0 : IDLE;
                end else if (bus.m0_req && w_term) begin
                    w_next = GNT0;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Tenure only accumulates while the owner keeps the bus and the other master is waiting.
    assign w_clr = (w_next != r_state) || !w_en;

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_term (w_term)
    );

    assign bus.m0_grant = (r_state == GNT0);
    assign bus.m1_grant = (r_state == GNT1);
    assign bus.bus_busy = (r_state != IDLE);
    assign bus.m_sel    = r_sel;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter with MAX_HOLD=4
module tb_bus_arbiter;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    bus_arbiter_if bif ();

    bus_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic g0, input logic g1, input logic sel, input logic busy);
        chk({tag, ".m0_grant"}, {7'd0, bif.m0_grant}, {7'd0, g0});
        chk({tag, ".m1_grant"}, {7'd0, bif.m1_grant}, {7'd0, g1});
        chk({tag, ".m_sel"},    {7'd0, bif.m_sel},    {7'd0, sel});
        chk({tag, ".bus_busy"}, {7'd0, bif.bus_busy}, {7'd0, busy});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("one_hot", {7'd0, bif.m0_grant & bif.m1_grant}, 8'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        bif.m0_req = 1'b1;
        bif.m1_req = 1'b0;

        // 1: reset holds everything low even with a request pending
        step();
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.hold_cnt", {5'd0, dut.u_hold.r_cnt}, 8'd0);
        reset = 1'b0;
        step();
        chk_out("first_m0", 1'b1, 1'b0, 1'b0, 1'b1);

        // 2: lone m1 request from IDLE, then release; m_sel keeps 1 in IDLE
        bif.m0_req = 1'b0;
        step();
        chk_out("m0_release", 1'b0, 1'b0, 1'b0, 1'b0);
        bif.m1_req = 1'b1;
        step();
        chk_out("m1_only", 1'b0, 1'b1, 1'b1, 1'b1);
        bif.m1_req = 1'b0;
        step();
        chk_out("m1_release", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: simultaneous requests from IDLE, released between rounds
        for (int i = 0; i < 4; i++) begin
            logic exp1;
`ifdef ARB_ROUND_ROBIN_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = 1'b0;
`endif
            bif.m0_req = 1'b1;
            bif.m1_req = 1'b1;
            step();
            chk_out($sformatf("tie%0d", i), !exp1, exp1, exp1, 1'b1);
            bif.m0_req = 1'b0;
            bif.m1_req = 1'b0;
            step();
            chk_out($sformatf("tie%0d_idle", i), 1'b0, 1'b0, exp1, 1'b0);
        end

        // 4: m0 owns, m1 waits; preemption after 4 cycles each way
        bif.m0_req = 1'b1;
        step();
        chk_out("pre_own0", 1'b1, 1'b0, 1'b0, 1'b1);
        bif.m1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("hold0_%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        chk("hold0.cnt", {5'd0, dut.u_hold.r_cnt}, 8'd3);
        step();
        chk_out("preempt_to1", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("preempt.cnt", {5'd0, dut.u_hold.r_cnt}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("hold1_%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
        end
        step();
        chk_out("preempt_to0", 1'b1, 1'b0, 1'b0, 1'b1);

        // 5: direct handover on m0 release while m1 waits
        bif.m0_req = 1'b0;
        step();
        chk_out("handover", 1'b0, 1'b1, 1'b1, 1'b1);

        // 6: asynchronous reset mid-GNT1 with accumulated tenure
        bif.m0_req = 1'b1;
        step();
        chk_out("gnt1_wait", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("gnt1_wait.cnt", {5'd0, dut.u_hold.r_cnt}, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("async_rst.cnt", {5'd0, dut.u_hold.r_cnt}, 8'd0);
        reset = 1'b0;
        step();
        chk_out("resume", 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
